// File: rtl/instruction_fetch_pkg.sv
// Shared definitions for the instruction fetch stage: FSM encoding and widths.
package instruction_fetch_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam logic [31:0] PC_STEP_DEFAULT = 32'd4;

  typedef enum logic {
    RUN  = 1'b0,
    MISS = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/fetch_perf_counter.sv
// Saturating 32-bit event counter with synchronous clear.
// Only built when FETCH_PERF_COUNTERS_EN is defined.
`ifdef FETCH_PERF_COUNTERS_EN
module fetch_perf_counter (
  input  logic        clock,
  input  logic        clear,
  input  logic        incEn,
  output logic [31:0] count
);

  logic [31:0] countQ, countD;

  always_comb begin
    countD = countQ;
    if (incEn && (countQ != 32'hFFFF_FFFF)) begin
      countD = countQ + 32'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      countQ <= 32'd0;
    end else begin
      countQ <= countD;
    end
  end

  assign count = countQ;

endmodule
`endif

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, sequences icache misses, stalls and branch redirects.
// Define FETCH_PERF_COUNTERS_EN to add missCount/squashCount outputs.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = PC_STEP_DEFAULT
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               stall,
  input  logic               branchTaken,
  input  logic [31:0]        branchTarget,
  output logic               icacheReq,
  output logic [31:0]        icacheAddr,
  input  logic               icacheHit,
  input  logic [INSTR_W-1:0] icacheData,
  input  logic               memReady,
  output logic [INSTR_W-1:0] instructionOutput,
  output logic [31:0]        nextPcOutput,
`ifdef FETCH_PERF_COUNTERS_EN
  output logic [31:0]        missCount,
  output logic [31:0]        squashCount,
`endif
  output logic               hitOutput
);

  fetch_state_e stateQ, stateD;
  logic [31:0]  pcQ, pcD;
  logic         pendValidQ, pendValidD;
  logic [31:0]  pendTargetQ, pendTargetD;
  logic [31:0]  alignedTarget;
  logic [31:0]  pcPlusStep;
  logic         unusedTargetBits;

  assign alignedTarget    = {branchTarget[31:2], 2'b00};
  assign unusedTargetBits = ^branchTarget[1:0];
  assign pcPlusStep       = pcQ + PC_STEP;

  assign icacheAddr        = pcQ;
  assign icacheReq         = !reset;
  assign instructionOutput = icacheData;
  assign nextPcOutput      = pcPlusStep;
  assign hitOutput         = !reset && (stateQ == RUN) && icacheHit && !stall && !branchTaken;

  always_comb begin
    stateD      = stateQ;
    pcD         = pcQ;
    pendValidD  = pendValidQ;
    pendTargetD = pendTargetQ;
    unique case (stateQ)
      RUN: begin
        if (branchTaken) begin
          pcD = alignedTarget;
        end else if (stall) begin
          pcD = pcQ;
        end else if (!icacheHit) begin
          stateD = MISS;
        end else begin
          pcD = pcPlusStep;
        end
      end
      MISS: begin
        // Branches seen during a refill are remembered; the newest one wins.
        if (branchTaken) begin
          pendValidD  = 1'b1;
          pendTargetD = alignedTarget;
        end
        if (memReady) begin
          stateD     = RUN;
          pendValidD = 1'b0;
          if (branchTaken) begin
            pcD = alignedTarget;
          end else if (pendValidQ) begin
            pcD = pendTargetQ;
          end
        end
      end
      default: stateD = RUN;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      stateQ      <= RUN;
      pcQ         <= RESET_PC;
      pendValidQ  <= 1'b0;
      pendTargetQ <= 32'd0;
    end else begin
      stateQ      <= stateD;
      pcQ         <= pcD;
      pendValidQ  <= pendValidD;
      pendTargetQ <= pendTargetD;
    end
  end

`ifdef FETCH_PERF_COUNTERS_EN
  logic missInc, squashInc;

  assign missInc   = (stateQ == RUN) && !branchTaken && !stall && !icacheHit;
  assign squashInc = (stateQ == RUN) && branchTaken && icacheHit;

  fetch_perf_counter uMissCounter (
    .clock (clock),
    .clear (reset),
    .incEn (missInc),
    .count (missCount)
  );

  fetch_perf_counter uSquashCounter (
    .clock (clock),
    .clear (reset),
    .incEn (squashInc),
    .count (squashCount)
  );
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed testbench for instruction_fetch with a simple address-derived icache model.
module tb_instruction_fetch;

  localparam logic [31:0] DATA_KEY = 32'hDEAD_0000;

  logic        clock = 1'b0;
  logic        reset;
  logic        stall;
  logic        branchTaken;
  logic [31:0] branchTarget;
  logic        icacheReq;
  logic [31:0] icacheAddr;
  logic        icacheHit;
  logic [31:0] icacheData;
  logic        memReady;
  logic [31:0] instructionOutput;
  logic [31:0] nextPcOutput;
  logic        hitOutput;
`ifdef FETCH_PERF_COUNTERS_EN
  logic [31:0] missCount;
  logic [31:0] squashCount;
`endif

  int assertCount = 0;
  int failCount   = 0;

  always #5 clock = ~clock;

  // The cache returns a word derived from the requested address.
  assign icacheData = icacheAddr ^ DATA_KEY;

  instruction_fetch #(
    .RESET_PC (32'h0000_0000),
    .PC_STEP  (32'd4)
  ) dut (
    .clock             (clock),
    .reset             (reset),
    .stall             (stall),
    .branchTaken       (branchTaken),
    .branchTarget      (branchTarget),
    .icacheReq         (icacheReq),
    .icacheAddr        (icacheAddr),
    .icacheHit         (icacheHit),
    .icacheData        (icacheData),
    .memReady          (memReady),
    .instructionOutput (instructionOutput),
    .nextPcOutput      (nextPcOutput),
`ifdef FETCH_PERF_COUNTERS_EN
    .missCount         (missCount),
    .squashCount       (squashCount),
`endif
    .hitOutput         (hitOutput)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus();
    @(posedge clock);
    #1;
  endtask

  task automatic checkFetch(input string tag, input logic [31:0] pc, input logic hit);
    #1;
    checkOutput({tag, ".addr"}, icacheAddr, pc);
    checkOutput({tag, ".hit"}, {31'd0, hitOutput}, {31'd0, hit});
    if (hit) begin
      checkOutput({tag, ".instr"}, instructionOutput, pc ^ DATA_KEY);
      checkOutput({tag, ".nextPc"}, nextPcOutput, pc + 32'd4);
    end
  endtask

  initial begin
    reset        = 1'b1;
    stall        = 1'b0;
    branchTaken  = 1'b0;
    branchTarget = 32'd0;
    icacheHit    = 1'b1;
    memReady     = 1'b0;
    applyStimulus();
    applyStimulus();
    #1;
    checkOutput("reset.req", {31'd0, icacheReq}, 32'd0);
    checkOutput("reset.hit", {31'd0, hitOutput}, 32'd0);
    checkOutput("reset.addr", icacheAddr, 32'd0);

    // Sequential hits from RESET_PC
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checkFetch("seq", 32'(i * 4), 1'b1);
      applyStimulus();
    end

    // Miss at 0x10, refill arrives three cycles later
    icacheHit = 1'b0;
    checkFetch("missRun", 32'h10, 1'b0);
    applyStimulus();
    checkFetch("miss1", 32'h10, 1'b0);
    applyStimulus();
    checkFetch("miss2", 32'h10, 1'b0);
    applyStimulus();
    memReady = 1'b1;
    checkFetch("miss3", 32'h10, 1'b0);
    applyStimulus();
    memReady  = 1'b0;
    icacheHit = 1'b1;
    checkFetch("refillHit", 32'h10, 1'b1);
    applyStimulus();
    checkFetch("afterRefill", 32'h14, 1'b1);

    // Branch overrides stall and squashes the current word
    stall        = 1'b1;
    branchTaken  = 1'b1;
    branchTarget = 32'h103;
    checkFetch("brStall", 32'h14, 1'b0);
    applyStimulus();
    stall       = 1'b0;
    branchTaken = 1'b0;
    checkFetch("brTarget", 32'h100, 1'b1);
    applyStimulus();

    // Two branches during a miss: the later target is taken on refill
    icacheHit = 1'b0;
    checkFetch("miss2Run", 32'h104, 1'b0);
    applyStimulus();
    branchTaken  = 1'b1;
    branchTarget = 32'h200;
    checkFetch("missBr1", 32'h104, 1'b0);
    applyStimulus();
    branchTarget = 32'h300;
    checkFetch("missBr2", 32'h104, 1'b0);
    applyStimulus();
    branchTaken = 1'b0;
    memReady    = 1'b1;
    checkFetch("missReady", 32'h104, 1'b0);
    applyStimulus();
    memReady  = 1'b0;
    icacheHit = 1'b1;
    checkFetch("pendRedirect", 32'h300, 1'b1);
    applyStimulus();
    // A plain miss after that must not reuse the consumed pending target
    icacheHit = 1'b0;
    applyStimulus();
    memReady = 1'b1;
    applyStimulus();
    memReady  = 1'b0;
    icacheHit = 1'b1;
    checkFetch("pendCleared", 32'h304, 1'b1);

    // Stall two cycles at 0x20
    branchTaken  = 1'b1;
    branchTarget = 32'h20;
    applyStimulus();
    branchTaken = 1'b0;
    stall       = 1'b1;
    checkFetch("stall1", 32'h20, 1'b0);
    applyStimulus();
    checkFetch("stall2", 32'h20, 1'b0);
    applyStimulus();
    stall = 1'b0;
    checkFetch("stallRelease", 32'h20, 1'b1);
    applyStimulus();
    checkFetch("stallAdvance", 32'h24, 1'b1);

    // PC wrap at the top of the address space
    branchTaken  = 1'b1;
    branchTarget = 32'hFFFF_FFFF;
    applyStimulus();
    branchTaken = 1'b0;
    checkFetch("wrapTop", 32'hFFFF_FFFC, 1'b1);
    checkOutput("wrapNextPc", nextPcOutput, 32'h0);
    applyStimulus();
    checkFetch("wrapZero", 32'h0, 1'b1);

    // Reset in the middle of a miss discards the pending branch
    icacheHit = 1'b0;
    applyStimulus();
    branchTaken  = 1'b1;
    branchTarget = 32'h400;
    checkFetch("rstMiss", 32'h0, 1'b0);
`ifdef FETCH_PERF_COUNTERS_EN
    checkOutput("missCount", missCount, 32'd4);
    checkOutput("squashCount", squashCount, 32'd3);
`endif
    applyStimulus();
    branchTaken = 1'b0;
    reset       = 1'b1;
    applyStimulus();
    #1;
    checkOutput("midReset.req", {31'd0, icacheReq}, 32'd0);
    checkOutput("midReset.hit", {31'd0, hitOutput}, 32'd0);
    reset     = 1'b0;
    icacheHit = 1'b1;
    checkFetch("postReset", 32'h0, 1'b1);
`ifdef FETCH_PERF_COUNTERS_EN
    checkOutput("missCountClr", missCount, 32'd0);
    checkOutput("squashCountClr", squashCount, 32'd0);
`endif
    icacheHit = 1'b0;
    applyStimulus();
    memReady = 1'b1;
    applyStimulus();
    memReady  = 1'b0;
    icacheHit = 1'b1;
    checkFetch("pendDiscarded", 32'h0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
